// File: rtl/ms_timer_pkg.sv
// Shared definitions for the millisecond timer scheduler: command encodings,
// sweep FSM states and default widths.
package ms_timer_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_CH_W   = 2;

  localparam logic [1:0] OP_START     = 2'b00;
  localparam logic [1:0] OP_STOP      = 2'b01;
  localparam logic [1:0] OP_START_PER = 2'b10;
  localparam logic [1:0] OP_NOP       = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/ms_timer_scheduler.sv
// NUM_CH countdown timers sharing one decrementer, swept once per 1 ms tick.
// Optional periodic reload is enabled by defining MS_TIMER_AUTO_RELOAD_EN.
module ms_timer_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1ms,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_value,
  output logic [NUM_CH-1:0] active,
  output logic [NUM_CH-1:0] expire,
  output logic              overrun
);
  import ms_timer_pkg::*;

  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

  sweep_state_t      state, state_nxt;
  logic [CH_W-1:0]   idx, idx_nxt;
  logic              tick_pending;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic              cmd_fire;

`ifdef MS_TIMER_AUTO_RELOAD_EN
  logic [CNT_W-1:0]  reload [NUM_CH];
  logic [NUM_CH-1:0] periodic;
`endif

  assign cmd_ready = (state == IDLE) && !reset;
  assign cmd_fire  = cmd_valid && (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (tick_1ms || tick_pending) begin
          state_nxt = SWEEP;
          idx_nxt   = '0;
        end
      end
      SWEEP: begin
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt = idx + CH_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Commands are only accepted in IDLE and the sweep only runs in SWEEP, so
  // the two never write the same counter in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_pending <= 1'b0;
      overrun      <= 1'b0;
      active       <= '0;
      expire       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
`ifdef MS_TIMER_AUTO_RELOAD_EN
      periodic <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        reload[i] <= '0;
      end
`endif
    end else begin
      expire <= '0;
      if (state == IDLE) begin
        if (tick_1ms || tick_pending) begin
          tick_pending <= 1'b0;
        end
        if (cmd_fire) begin
          case (cmd_op)
            OP_START, OP_START_PER: begin
              if (cmd_value != '0) begin
                cnt[cmd_ch]    <= cmd_value;
                active[cmd_ch] <= 1'b1;
              end else begin
                cnt[cmd_ch]    <= '0;
                active[cmd_ch] <= 1'b0;
                expire[cmd_ch] <= 1'b1;
              end
`ifdef MS_TIMER_AUTO_RELOAD_EN
              periodic[cmd_ch] <= (cmd_op == OP_START_PER) && (cmd_value != '0);
              if (cmd_op == OP_START_PER) begin
                reload[cmd_ch] <= cmd_value;
              end
`endif
            end
            OP_STOP: begin
              active[cmd_ch] <= 1'b0;
`ifdef MS_TIMER_AUTO_RELOAD_EN
              periodic[cmd_ch] <= 1'b0;
`endif
            end
            default: ;
          endcase
        end
      end else begin
        if (tick_1ms) begin
          if (tick_pending) begin
            overrun <= 1'b1;
          end else begin
            tick_pending <= 1'b1;
          end
        end
        if (active[idx] && (cnt[idx] != '0)) begin
          if (cnt[idx] == CNT_W'(1)) begin
            expire[idx] <= 1'b1;
`ifdef MS_TIMER_AUTO_RELOAD_EN
            if (periodic[idx]) begin
              cnt[idx] <= reload[idx];
            end else begin
              cnt[idx]    <= '0;
              active[idx] <= 1'b0;
            end
`else
            cnt[idx]    <= '0;
            active[idx] <= 1'b0;
`endif
          end else begin
            cnt[idx] <= cnt[idx] - CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ms_timer_scheduler.sv
// Directed self-checking bench for ms_timer_scheduler (NUM_CH=4, CNT_W=16).
// Covers the periodic path when MS_TIMER_AUTO_RELOAD_EN is defined.
module tb_ms_timer_scheduler;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;
  localparam int GAP    = 200 - (NUM_CH + 2);

  logic              clk = 1'b0;
  logic              reset;
  logic              tick_1ms;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch;
  logic [1:0]        cmd_op;
  logic [CNT_W-1:0]  cmd_value;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] expire;
  logic              overrun;

  int n_chk  = 0;
  int n_fail = 0;

  logic [NUM_CH-1:0] ex [NUM_CH+1];
  logic [NUM_CH-1:0] ac [NUM_CH+1];
  logic [NUM_CH-1:0] seen [8];

  ms_timer_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_op(cmd_op), .cmd_value(cmd_value),
    .active(active), .expire(expire), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [CH_W-1:0] ch, input logic [1:0] op, input logic [CNT_W-1:0] v);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin
      step();
      w++;
    end
    if (w == 20) chk("cmd_ready_wait", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_op    = op;
    cmd_value = v;
    step();
    cmd_valid = 1'b0;
  endtask

  // ex[k]/ac[k] hold expire/active k+1 cycles after the tick cycle's edge,
  // so channel i expiring on this sweep shows up in ex[i].
  task automatic do_tick();
    tick_1ms = 1'b1;
    step();
    tick_1ms = 1'b0;
    for (int k = 0; k <= NUM_CH; k++) begin
      step();
      ex[k] = expire;
      ac[k] = active;
    end
    repeat (GAP) step();
  endtask

  function automatic logic [NUM_CH-1:0] any_ex();
    logic [NUM_CH-1:0] r;
    r = '0;
    for (int k = 0; k <= NUM_CH; k++) r |= ex[k];
    return r;
  endfunction

  initial begin
    reset     = 1'b1;
    tick_1ms  = 1'b0;
    cmd_valid = 1'b0;
    cmd_ch    = '0;
    cmd_op    = 2'b00;
    cmd_value = '0;
    repeat (3) step();
    chk("rst_ready",   32'(cmd_ready), 0);
    chk("rst_active",  32'(active),    0);
    chk("rst_expire",  32'(expire),    0);
    chk("rst_overrun", 32'(overrun),   0);
    reset = 1'b0;
    step();
    chk("idle_ready", 32'(cmd_ready), 1);

    // one-shot ch0 = 3
    cmd(2'd0, 2'b00, 16'd3);
    chk("t1_active", 32'(active), 'h1);
    tick_1ms = 1'b1;
    step();
    tick_1ms = 1'b0;
    chk("t1_ready_sweep", 32'(cmd_ready), 0);
    repeat (NUM_CH + 1 + GAP) step();
    do_tick();
    chk("t1_no_exp_2", 32'(any_ex()), 0);
    do_tick();
    chk("t1_exp_0",    32'(ex[0]), 'h1);
    chk("t1_act_fall", 32'(ac[0]), 'h0);
    chk("t1_pulse",    32'(ex[1]), 'h0);

    // ch1 = 5, ch2 = 2
    cmd(2'd1, 2'b00, 16'd5);
    cmd(2'd2, 2'b00, 16'd2);
    chk("t2_active", 32'(active), 'h6);
    do_tick();
    chk("t2_tick1", 32'(any_ex()), 0);
    do_tick();
    chk("t2_exp2", 32'(ex[2]), 'h4);
    chk("t2_only2", 32'(any_ex()), 'h4);
    chk("t2_act2", 32'(ac[2]), 'h2);
    do_tick();
    do_tick();
    chk("t2_tick4", 32'(any_ex()), 0);
    do_tick();
    chk("t2_exp1", 32'(ex[1]), 'h2);
    chk("t2_act1", 32'(ac[1]), 'h0);

    // ch3 = 4, stopped after two ticks
    cmd(2'd3, 2'b00, 16'd4);
    do_tick();
    do_tick();
    chk("t3_run", 32'(ac[NUM_CH]), 'h8);
    cmd(2'd3, 2'b01, 16'd0);
    chk("t3_stop", 32'(active), 'h0);
    for (int t = 0; t < 3; t++) begin
      do_tick();
      chk("t3_no_exp", 32'(any_ex()), 0);
      chk("t3_inact", 32'(ac[NUM_CH]), 0);
    end

    // zero-length start, reserved op, restart overwrite
    cmd(2'd0, 2'b00, 16'd0);
    chk("t4_exp0", 32'(expire), 'h1);
    chk("t4_act0", 32'(active), 'h0);
    step();
    chk("t4_pulse", 32'(expire), 'h0);
    cmd(2'd2, 2'b11, 16'd7);
    chk("t4_nop", 32'(active), 'h0);
    cmd(2'd1, 2'b00, 16'd5);
    cmd(2'd1, 2'b00, 16'd1);
    do_tick();
    chk("t4_restart", 32'(ex[1]), 'h2);

    // three back-to-back ticks: one runs, one pends, one is dropped
    cmd(2'd0, 2'b00, 16'd2);
    tick_1ms = 1'b1;
    repeat (3) step();
    tick_1ms = 1'b0;
    chk("t5_overrun", 32'(overrun), 1);
    for (int k = 0; k < 8; k++) begin
      step();
      seen[k] = expire;
    end
    chk("t5_pend_exp", 32'(seen[3]), 'h1);
    chk("t5_pend_one", 32'(seen[2] | seen[4] | seen[5] | seen[6] | seen[7]), 0);
    repeat (50) step();
    chk("t5_sticky", 32'(overrun), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("t5_rst_ovr", 32'(overrun), 0);

    // reset in the middle of a sweep
    cmd(2'd1, 2'b00, 16'd1);
    tick_1ms = 1'b1;
    step();
    tick_1ms = 1'b0;
    reset = 1'b1;
    step();
    chk("t6_act", 32'(active), 0);
    chk("t6_exp", 32'(expire), 0);
    chk("t6_ovr", 32'(overrun), 0);
    chk("t6_ready", 32'(cmd_ready), 0);
    reset = 1'b0;
    step();
    chk("t6_idle", 32'(cmd_ready), 1);
    repeat (NUM_CH + 2) begin
      step();
      chk("t6_quiet", 32'(expire), 0);
    end

`ifdef MS_TIMER_AUTO_RELOAD_EN
    cmd(2'd1, 2'b10, 16'd2);
    for (int t = 1; t <= 6; t++) begin
      do_tick();
      chk("t7_per_exp", 32'(any_ex()), (t % 2 == 0) ? 'h2 : 'h0);
      chk("t7_per_act", 32'(ac[NUM_CH]), 'h2);
    end
    cmd(2'd1, 2'b01, 16'd0);
    chk("t7_stop", 32'(active), 0);
    do_tick();
    do_tick();
    chk("t7_stopped", 32'(any_ex()), 0);
`else
    cmd(2'd1, 2'b10, 16'd2);
    do_tick();
    chk("t7_os_t1", 32'(any_ex()), 0);
    do_tick();
    chk("t7_os_exp", 32'(ex[1]), 'h2);
    chk("t7_os_act", 32'(ac[NUM_CH]), 0);
    do_tick();
    do_tick();
    chk("t7_os_done", 32'(any_ex()), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
